// File: rtl/gpio_pkg.sv
// Shared widths and types for the GPIO input capture block.
package gpio_pkg;

  localparam int unsigned GPIO_WIDTH = 16;
  localparam int unsigned GPIO_CNT_W = 8;

  typedef logic [GPIO_WIDTH-1:0] gpio_data_t;
  typedef logic [GPIO_CNT_W-1:0] gpio_cnt_t;

endpackage

// File: rtl/gpio_bit_filter.sv
// Per-pin 2-flop synchronizer, optional debounce counter and edge flags.
// Debounce counter exists only when GPIO_IN_CAPTURE_DEBOUNCE_EN is defined.
module gpio_bit_filter
  import gpio_pkg::*;
#(
  parameter int unsigned CNT_W = GPIO_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pin_i,
  input  logic [CNT_W-1:0] debounce_cycles_i,
  output logic             data_o,
  output logic             rise_o,
  output logic             fall_o
);

  logic sync1_q, sync2_q;
  logic data_q, data_d;
  logic update;

`ifdef GPIO_IN_CAPTURE_DEBOUNCE_EN
  logic [CNT_W-1:0] cnt_q, cnt_d, thresh;

  // N=0 and N=1 both commit on the first differing cycle.
  always_comb begin
    thresh = (debounce_cycles_i == '0) ? '0 : debounce_cycles_i - CNT_W'(1);
    update = (sync2_q != data_q) && (cnt_q == thresh);
    cnt_d  = cnt_q;
    if ((sync2_q == data_q) || update) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_debounce;
  assign unused_debounce = ^debounce_cycles_i;
  assign update          = (sync2_q != data_q);
`endif

  always_comb begin
    data_d = data_q;
    if (update) begin
      data_d = sync2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      data_q  <= 1'b0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      data_q  <= data_d;
    end
  end

  // Events fire in the same cycle data_q is about to change.
  assign data_o = data_q;
  assign rise_o = update & sync2_q;
  assign fall_o = update & ~sync2_q;

endmodule

// File: rtl/gpio_in_capture.sv
// GPIO input capture: per-pin filtering plus sticky edge interrupt status.
// Debounce is enabled by defining GPIO_IN_CAPTURE_DEBOUNCE_EN; otherwise bypass.
module gpio_in_capture
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH = GPIO_WIDTH,
  parameter int unsigned CNT_W = GPIO_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gpio_pin,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [CNT_W-1:0] debounce_cycles,
  input  logic [WIDTH-1:0] irq_clr,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] irq_status,
  output logic             irq_o
);

  logic [WIDTH-1:0] rise, fall;
  logic [WIDTH-1:0] irq_status_q, irq_status_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_bit_filter #(
      .CNT_W(CNT_W)
    ) u_filter (
      .clk              (clk),
      .rst_n            (rst_n),
      .pin_i            (gpio_pin[i]),
      .debounce_cycles_i(debounce_cycles),
      .data_o           (data_o[i]),
      .rise_o           (rise[i]),
      .fall_o           (fall[i])
    );
  end

  // Set takes priority over a simultaneous clear.
  always_comb begin
    irq_status_d = (irq_status_q & ~irq_clr) | (rise & rise_en) | (fall & fall_en);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_status_q <= '0;
    end else begin
      irq_status_q <= irq_status_d;
    end
  end

  assign irq_status = irq_status_q;
  assign irq_o      = |irq_status_q;

endmodule

// File: tb/tb_gpio_in_capture.sv
// Self-checking bench for gpio_in_capture: directed scenarios plus randomized
// stimulus against a run-length reference model.
module tb_gpio_in_capture;

`ifdef GPIO_IN_CAPTURE_DEBOUNCE_EN
  localparam bit DebEn = 1'b1;
`else
  localparam bit DebEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] gpio_pin, rise_en, fall_en, irq_clr;
  logic [7:0]  debounce_cycles;
  logic [15:0] data_o, irq_status;
  logic        irq_o;

  int checks   = 0;
  int failures = 0;

  gpio_in_capture #(
    .WIDTH(16),
    .CNT_W(8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .gpio_pin       (gpio_pin),
    .rise_en        (rise_en),
    .fall_en        (fall_en),
    .debounce_cycles(debounce_cycles),
    .irq_clr        (irq_clr),
    .data_o         (data_o),
    .irq_status     (irq_status),
    .irq_o          (irq_o)
  );

  always #5 clk = ~clk;

  // Reference model: a pin commits once its synchronized level has disagreed
  // with the output for max(N,1) consecutive cycles (always 1 without debounce).
  logic [15:0] m_s1, m_s2, m_data, m_stat;
  int          m_run [16];

  always @(posedge clk) begin : model
    logic [15:0] dn, stn;
    int          runn [16];
    int          effn;
    if (!rst_n) begin
      m_s1   <= '0;
      m_s2   <= '0;
      m_data <= '0;
      m_stat <= '0;
      m_run  <= '{default: 0};
    end else begin
      effn = (DebEn && debounce_cycles > 1) ? int'(debounce_cycles) : 1;
      dn   = m_data;
      stn  = m_stat & ~irq_clr;
      runn = m_run;
      for (int i = 0; i < 16; i++) begin
        if (m_s2[i] != m_data[i]) begin
          if (m_run[i] + 1 >= effn) begin
            dn[i]   = m_s2[i];
            runn[i] = 0;
            if ((m_s2[i] && rise_en[i]) || (!m_s2[i] && fall_en[i])) stn[i] = 1'b1;
          end else begin
            runn[i] = m_run[i] + 1;
          end
        end else begin
          runn[i] = 0;
        end
      end
      m_s1   <= gpio_pin;
      m_s2   <= m_s1;
      m_data <= dn;
      m_stat <= stn;
      m_run  <= runn;
    end
  end

  function automatic int lat_of(int n);
    return (DebEn && n > 1) ? n + 1 : 2;
  endfunction

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic quiesce();
    gpio_pin = '0;
    cyc(14);
    irq_clr = '1;
    cyc(1);
    irq_clr = '0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    gpio_pin = 16'hFFFF;
    cyc(3);
    checks += 3;
    if (data_o !== 16'h0) begin
      failures++; $display("FAIL reset_data got %h exp 0000", data_o);
    end
    if (irq_status !== 16'h0) begin
      failures++; $display("FAIL reset_status got %h exp 0000", irq_status);
    end
    if (irq_o !== 1'b0) begin
      failures++; $display("FAIL reset_irq got %b exp 0", irq_o);
    end
    gpio_pin = '0;
    rst_n    = 1'b1;
    cyc(4);
  endtask

  task automatic test_bypass();
    logic [15:0] e;
    quiesce();
    debounce_cycles = 8'd0;
    rise_en = 16'h0001;
    fall_en = 16'h0000;
    gpio_pin[0] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      cyc(1);
      e = (j >= 2) ? 16'h0001 : 16'h0000;
      checks += 3;
      if (data_o !== e) begin
        failures++; $display("FAIL bypass_data edge+%0d got %h exp %h", j, data_o, e);
      end
      if (irq_status !== e) begin
        failures++; $display("FAIL bypass_status edge+%0d got %h exp %h", j, irq_status, e);
      end
      if (irq_o !== e[0]) begin
        failures++; $display("FAIL bypass_irq edge+%0d got %b exp %b", j, irq_o, e[0]);
      end
    end
  endtask

  task automatic test_macro_latency();
    int lat;
    quiesce();
    debounce_cycles = 8'd8;
    rise_en = 16'h0002;
    lat = lat_of(8);
    gpio_pin[1] = 1'b1;
    for (int j = 0; j <= lat + 1; j++) begin
      cyc(1);
      checks += 2;
      if (data_o[1] !== (j >= lat)) begin
        failures++; $display("FAIL n8_latency edge+%0d got %b exp %b", j, data_o[1], j >= lat);
      end
      if (irq_status[1] !== (j >= lat)) begin
        failures++; $display("FAIL n8_status edge+%0d got %b exp %b", j, irq_status[1], j >= lat);
      end
    end
  endtask

  task automatic test_debounce();
    int lat;
    logic [15:0] es;
    quiesce();
    debounce_cycles = 8'd4;
    rise_en = 16'h0020;
    fall_en = 16'h0000;
    gpio_pin[5] = 1'b1;
    cyc(3);
    gpio_pin[5] = 1'b0;
    cyc(8);
    es = DebEn ? 16'h0000 : 16'h0020;
    checks += 2;
    if (data_o !== 16'h0) begin
      failures++; $display("FAIL glitch_data got %h exp 0000", data_o);
    end
    if (irq_status !== es) begin
      failures++; $display("FAIL glitch_status got %h exp %h", irq_status, es);
    end
    irq_clr = '1;
    cyc(1);
    irq_clr = '0;
    lat = lat_of(4);
    gpio_pin[5] = 1'b1;
    for (int j = 0; j <= lat + 1; j++) begin
      cyc(1);
      checks++;
      if (data_o[5] !== (j >= lat)) begin
        failures++; $display("FAIL hold_data edge+%0d got %b exp %b", j, data_o[5], j >= lat);
      end
    end
  endtask

  task automatic test_set_clear_race();
    quiesce();
    debounce_cycles = 8'd0;
    rise_en = 16'h0000;
    fall_en = 16'h0004;
    gpio_pin[2] = 1'b1;
    cyc(4);
    gpio_pin[2] = 1'b0;
    cyc(2);
    irq_clr = 16'h0004;
    cyc(1);
    checks += 2;
    if (irq_status !== 16'h0004) begin
      failures++; $display("FAIL race_set_wins got %h exp 0004", irq_status);
    end
    if (data_o[2] !== 1'b0) begin
      failures++; $display("FAIL race_data got %b exp 0", data_o[2]);
    end
    cyc(1);
    irq_clr = '0;
    checks += 2;
    if (irq_status !== 16'h0000) begin
      failures++; $display("FAIL race_clear got %h exp 0000", irq_status);
    end
    if (irq_o !== 1'b0) begin
      failures++; $display("FAIL race_irq got %b exp 0", irq_o);
    end
  endtask

  task automatic test_disabled_edge();
    quiesce();
    debounce_cycles = 8'd0;
    rise_en  = 16'h0000;
    fall_en  = 16'hFFFF;
    gpio_pin = 16'hFFFF;
    cyc(4);
    checks += 2;
    if (data_o !== 16'hFFFF) begin
      failures++; $display("FAIL dis_data got %h exp ffff", data_o);
    end
    if (irq_status !== 16'h0000) begin
      failures++; $display("FAIL dis_status got %h exp 0000", irq_status);
    end
    gpio_pin = 16'h0000;
    cyc(4);
    checks += 3;
    if (data_o !== 16'h0000) begin
      failures++; $display("FAIL dis_fall_data got %h exp 0000", data_o);
    end
    if (irq_status !== 16'hFFFF) begin
      failures++; $display("FAIL dis_fall_status got %h exp ffff", irq_status);
    end
    if (irq_o !== 1'b1) begin
      failures++; $display("FAIL dis_fall_irq got %b exp 1", irq_o);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [15:0] e;
    quiesce();
    debounce_cycles = 8'd10;
    rise_en = 16'hFFFF;
    fall_en = 16'h0000;
    gpio_pin[7] = 1'b1;
    cyc(5);
    rst_n = 1'b0;
    cyc(1);
    checks += 3;
    if (data_o !== 16'h0) begin
      failures++; $display("FAIL midrst_data got %h exp 0000", data_o);
    end
    if (irq_status !== 16'h0) begin
      failures++; $display("FAIL midrst_status got %h exp 0000", irq_status);
    end
    if (irq_o !== 1'b0) begin
      failures++; $display("FAIL midrst_irq got %b exp 0", irq_o);
    end
    rst_n = 1'b1;
    lat = lat_of(10);
    for (int j = 0; j <= lat + 1; j++) begin
      cyc(1);
      e = (j >= lat) ? 16'h0080 : 16'h0000;
      checks += 2;
      if (data_o !== e) begin
        failures++; $display("FAIL postrst_data edge+%0d got %h exp %h", j, data_o, e);
      end
      if (irq_status !== e) begin
        failures++; $display("FAIL postrst_status edge+%0d got %h exp %h", j, irq_status, e);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] n_tab [5];
    n_tab[0] = 8'd0; n_tab[1] = 8'd1; n_tab[2] = 8'd2; n_tab[3] = 8'd3; n_tab[4] = 8'd5;
    for (int seg = 0; seg < 10; seg++) begin
      // Pins are held steady before N changes so no count is in flight.
      cyc(14);
      debounce_cycles = n_tab[$urandom_range(0, 4)];
      rise_en = 16'($urandom);
      fall_en = 16'($urandom);
      for (int c = 0; c < 50; c++) begin
        cyc(1);
        checks += 3;
        if (data_o !== m_data) begin
          failures++; $display("FAIL rand_data seg %0d cyc %0d got %h exp %h", seg, c, data_o, m_data);
        end
        if (irq_status !== m_stat) begin
          failures++; $display("FAIL rand_status seg %0d cyc %0d got %h exp %h", seg, c, irq_status, m_stat);
        end
        if (irq_o !== (|m_stat)) begin
          failures++; $display("FAIL rand_irq seg %0d cyc %0d got %b exp %b", seg, c, irq_o, |m_stat);
        end
        gpio_pin = gpio_pin ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
        irq_clr  = 16'($urandom) & 16'($urandom) & 16'($urandom);
      end
      irq_clr = '0;
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    gpio_pin        = '0;
    rise_en         = '0;
    fall_en         = '0;
    irq_clr         = '0;
    debounce_cycles = '0;
    test_reset();
    test_bypass();
    test_macro_latency();
    test_debounce();
    test_set_clear_race();
    test_disabled_edge();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
